uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter size, 32: number of data bits per frame.
REQ-002 Parameter MAX_RETRY, 3: maximum consecutive parity-error retransmissions requested per frame.
REQ-003 Parameter PARITY_ODD, 0: 0 selects even parity (parity bit = XOR of data bits); 1 selects odd parity.
REQ-004 Port CLK_Baudin, input, 1: the single baud clock; one line sample per rising edge.
REQ-005 Port RstRx, input, 1: reset, synchronous and active-high.
REQ-006 Port RxSerialData, input, 1: serial line; idles at 1.
REQ-007 Port DataOut, output, size: last correctly received word, LSB received first.
REQ-008 Port DoneRx, output, 1: one-cycle pulse when DataOut is updated.
REQ-009 Port Flag_out, output, 1: retransmit request to the transmitter's Flag_in.
REQ-010 Port ParityErr, output, 1: one-cycle pulse when a frame is dropped after retries are exhausted.
REQ-011 Port FrameErr, output, 1: one-cycle pulse when a frame is dropped because the stop bit is bad.
REQ-012 Port BusyRx, output, 1: high in every state except IDLE.

Function
REQ-013 States: IDLE, DATA, PARITY, RETRY, STOP; all transitions occur on rising edges of CLK_Baudin.
REQ-014 IDLE: on a sample of 0, go to DATA and clear the bit counter, shift register and running parity; on a sample of 1, stay in IDLE.
REQ-015 DATA: on each edge, shift the sample into bit [counter] (LSB first) and XOR it into the running parity; after sample number size, go to PARITY.
REQ-016 PARITY: expected bit = running parity XOR PARITY_ODD; compare it with the current line sample on the edge that samples it.
REQ-017 Flag_out: Mealy output, high only while in PARITY, the line differs from the expected bit, and the retry count is below MAX_RETRY.
REQ-018 Parity match: go to STOP.
REQ-019 Mismatch with retries remaining: increment the retry count and go to RETRY.
REQ-020 Mismatch with retries exhausted: latch the parity-fail flag and go to STOP, with Flag_out low.
REQ-021 RETRY: ignore exactly one sample (the transmitter is still holding the parity bit), then go to DATA with the counter, shift register and running parity cleared; no start bit is expected.
REQ-022 STOP: a sample of 1 with no parity-fail latched registers the shift register into DataOut and pulses DoneRx.
REQ-023 STOP: a sample of 1 with parity-fail latched pulses ParityErr.
REQ-024 STOP: a sample of 0 pulses FrameErr (FrameErr takes priority over ParityErr).
REQ-025 STOP: in all cases, go to IDLE on the same edge and clear the retry count and parity-fail flag.
REQ-026 DataOut changes only on a DoneRx pulse; pulses are mutually exclusive and exactly one cycle wide.
REQ-027 The bit counter is $clog2(size)+1 bits wide; the retry counter is $clog2(MAX_RETRY+1) bits wide; neither counter wraps.
REQ-028 A start bit sampled on the cycle directly after a STOP edge is accepted (zero-gap back-to-back frames).

Reset
REQ-029 When RstRx is high at an edge: state = IDLE, DataOut = 0, DoneRx/ParityErr/FrameErr = 0, Flag_out = 0, BusyRx = 0, all counters and flags cleared.
REQ-030 Reset mid-frame abandons the frame silently: no pulse is generated and DataOut is unchanged from its reset value.

Structure
REQ-031 Shared package uart_pkg holds the state encoding, the default size and the parity-mode constants; uart_rx and the transmitter share it.
REQ-032 Sub-module uart_rx_parity_acc provides the running XOR, with clear and enable inputs.

Verification
REQ-033 Clean frame 0xA5A50F0F (parity 0), stop 1 -> DoneRx pulses once, DataOut = 0xA5A50F0F, Flag_out stays 0.
REQ-034 Same frame with parity bit 1 -> Flag_out high for 1 cycle; after 1 ignored cycle, 32 bits of 0x12345678 with correct parity and stop -> DoneRx, DataOut = 0x12345678.
REQ-035 MAX_RETRY = 3 with 4 consecutive bad parity bits -> Flag_out pulses 3 times, stays low on the 4th; stop 1 -> ParityErr pulse, DoneRx 0, DataOut unchanged.
REQ-036 Frame 0x0000FFFF with stop 0 -> FrameErr pulse and return to IDLE; next frame 0x00000001 -> DoneRx, DataOut = 0x00000001.
REQ-037 RstRx asserted at data bit 10 -> BusyRx = 0 on the next cycle and no pulses; a subsequent frame 0xDEADBEEF is received correctly.
REQ-038 Two zero-gap frames 0xFFFFFFFF then 0x80000000 -> two DoneRx pulses with the matching DataOut values.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default word size and
// parity-mode constants used by both the receiver and the transmitter.
package uart_pkg;

    // Default number of data bits carried in one frame.
    localparam int DEFAULT_SIZE = 32;

    // Parity-mode selectors for the PARITY_ODD parameter.
    localparam bit PAR_MODE_EVEN = 1'b0;
    localparam bit PAR_MODE_ODD  = 1'b1;

    // Receiver states. Any state other than RX_IDLE means a frame is in flight.
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_DATA   = 3'd1,
        RX_PARITY = 3'd2,
        RX_RETRY  = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_parity_acc.sv
// Running XOR of the data bits of the current frame attempt.
// clr has priority over en so a fresh attempt always starts from zero.
module uart_rx_parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic parity
);

    logic par_q;
    logic par_d;

    // Next running parity: clear, fold in the new bit, or hold.
    always_comb begin
        par_d = par_q;
        if (clr) begin
            par_d = 1'b0;
        end else if (en) begin
            par_d = par_q ^ bit_in;
        end
    end

    // Parity register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign parity = par_q;

endmodule : uart_rx_parity_acc

// File: rtl/uart_rx.sv
// UART receiver with parity-error retransmission requests.
// One line sample per rising edge of CLK_Baudin; no oversampling.
// Handshake: DoneRx, ParityErr and FrameErr are single-cycle, mutually
// exclusive pulses; DataOut is only updated on the cycle DoneRx is high.
// Flag_out is a Mealy request that is valid while the parity bit is on the line.
module uart_rx
    import uart_pkg::*;
#(
    parameter int size       = DEFAULT_SIZE,
    parameter int MAX_RETRY  = 3,
    parameter bit PARITY_ODD = PAR_MODE_EVEN
) (
    input  logic            CLK_Baudin,
    input  logic            RstRx,
    input  logic            RxSerialData,
    output logic [size-1:0] DataOut,
    output logic            DoneRx,
    output logic            Flag_out,
    output logic            ParityErr,
    output logic            FrameErr,
    output logic            BusyRx
);

    localparam int CNT_W   = $clog2(size) + 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(size - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    rx_state_e         state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [size-1:0]   shift_q,  shift_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic              fail_q,   fail_d;
    logic [size-1:0]   data_q,   data_d;
    logic              done_q,   done_d;
    logic              perr_q,   perr_d;
    logic              ferr_q,   ferr_d;

    logic par_clr;
    logic par_en;
    logic par_run;
    logic par_exp;
    logic par_bad;
    logic retry_left;

    uart_rx_parity_acc u_parity_acc (
        .clk    (CLK_Baudin),
        .rst    (RstRx),
        .clr    (par_clr),
        .en     (par_en),
        .bit_in (RxSerialData),
        .parity (par_run)
    );

    assign par_exp    = par_run ^ PARITY_ODD;
    assign par_bad    = (RxSerialData != par_exp);
    assign retry_left = (retry_q < RETRY_MAX);

    // Next-state and datapath control for the frame FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        retry_d = retry_q;
        fail_d  = fail_q;
        data_d  = data_q;
        done_d  = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        par_clr = 1'b0;
        par_en  = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                if (!RxSerialData) begin
                    state_d = RX_DATA;
                    cnt_d   = '0;
                    shift_d = '0;
                    par_clr = 1'b1;
                end
            end
            RX_DATA: begin
                // Shifting in from the top leaves the first bit in bit 0
                // after exactly size samples.
                shift_d = {RxSerialData, shift_q[size-1:1]};
                par_en  = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = RX_PARITY;
                end
            end
            RX_PARITY: begin
                if (!par_bad) begin
                    state_d = RX_STOP;
                end else if (retry_left) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = RX_RETRY;
                end else begin
                    fail_d  = 1'b1;
                    state_d = RX_STOP;
                end
            end
            RX_RETRY: begin
                // Transmitter is still holding its parity bit; the resent
                // word starts on the next sample with no start bit.
                state_d = RX_DATA;
                cnt_d   = '0;
                shift_d = '0;
                par_clr = 1'b1;
            end
            RX_STOP: begin
                if (!RxSerialData) begin
                    ferr_d = 1'b1;
                end else if (fail_q) begin
                    perr_d = 1'b1;
                end else begin
                    data_d = shift_q;
                    done_d = 1'b1;
                end
                state_d = RX_IDLE;
                retry_d = '0;
                fail_d  = 1'b0;
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge CLK_Baudin) begin
        if (RstRx) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            retry_q <= '0;
            fail_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            retry_q <= retry_d;
            fail_q  <= fail_d;
            data_q  <= data_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign DataOut   = data_q;
    assign DoneRx    = done_q;
    assign ParityErr = perr_q;
    assign FrameErr  = ferr_q;
    assign BusyRx    = (state_q != RX_IDLE);
    assign Flag_out  = (state_q == RX_PARITY) && par_bad && retry_left;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames followed by random frames,
// scored against a frame-level model of the receiver's behaviour.
module tb_uart_rx;

    localparam int W      = 32;
    localparam int TB_MAX = 3;
    localparam bit TB_ODD = 1'b0;

    logic         CLK_Baudin;
    logic         RstRx;
    logic         RxSerialData;
    logic [W-1:0] DataOut;
    logic         DoneRx;
    logic         Flag_out;
    logic         ParityErr;
    logic         FrameErr;
    logic         BusyRx;

    uart_rx #(
        .size       (W),
        .MAX_RETRY  (TB_MAX),
        .PARITY_ODD (TB_ODD)
    ) dut (
        .CLK_Baudin   (CLK_Baudin),
        .RstRx        (RstRx),
        .RxSerialData (RxSerialData),
        .DataOut      (DataOut),
        .DoneRx       (DoneRx),
        .Flag_out     (Flag_out),
        .ParityErr    (ParityErr),
        .FrameErr     (FrameErr),
        .BusyRx       (BusyRx)
    );

    // Clock and watchdog
    initial CLK_Baudin = 1'b0;
    always #5 CLK_Baudin = ~CLK_Baudin;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end within the time limit");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard state
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    int m_flags = 0, m_done = 0, m_perr = 0, m_ferr = 0;
    logic [W-1:0] m_last = '0;

    int n_flags = 0, n_done = 0, n_perr = 0, n_ferr = 0;
    bit mon_en = 1'b0;
    logic [W-1:0] data_prev = '0;
    logic rst_prev = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: samples mid-cycle, after inputs for the cycle are settled.
    always @(negedge CLK_Baudin) begin
        #2;
        if (mon_en) begin
            if (Flag_out) n_flags++;
            if (ParityErr) n_perr++;
            if (FrameErr) n_ferr++;
            if (DoneRx) begin
                n_done++;
                chk("done_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("dataout_word", DataOut, exp_q.pop_front());
            end
            chk("pulse_exclusive",
                (int'(DoneRx) + int'(ParityErr) + int'(FrameErr)) <= 1, 1'b1);
            if (!rst_prev && !DoneRx) chk("dataout_stable", DataOut, data_prev);
        end
        data_prev = DataOut;
        rst_prev  = RstRx;
    end

    // Driver tasks
    task automatic send_bit(input logic b);
        @(negedge CLK_Baudin);
        RxSerialData = b;
    endtask

    // Sends a frame; the first n_bad parity bits are corrupted. Retries carry retry_w.
    task automatic send_frame(input logic [W-1:0] first_w, input logic [W-1:0] retry_w,
                              input int n_bad, input bit stop_ok);
        logic [W-1:0] w;
        logic par;
        bit bad;
        bit sending;
        int a;
        int used;
        send_bit(1'b0);
        w = first_w;
        a = 0;
        sending = 1'b1;
        while (sending) begin
            for (int i = 0; i < W; i++) send_bit(w[i]);
            if (a == 0) begin
                #3;
                chk("busy_in_frame", BusyRx, 1'b1);
            end
            par = (^w) ^ TB_ODD;
            bad = (a < n_bad);
            send_bit(bad ? ~par : par);
            if (bad && a < TB_MAX) begin
                send_bit(1'($urandom_range(0, 1)));
                a++;
                w = retry_w;
            end else begin
                sending = 1'b0;
            end
        end
        send_bit(stop_ok);
        used = (n_bad < TB_MAX) ? n_bad : TB_MAX;
        m_flags += used;
        if (!stop_ok) begin
            m_ferr++;
        end else if (n_bad > TB_MAX) begin
            m_perr++;
        end else begin
            m_done++;
            m_last = (used == 0) ? first_w : retry_w;
            exp_q.push_back(m_last);
        end
    endtask

    task automatic checkpoint(input string tag);
        send_bit(1'b1);
        send_bit(1'b1);
        #3;
        chk({tag, ":done_count"}, n_done, m_done);
        chk({tag, ":flag_count"}, n_flags, m_flags);
        chk({tag, ":perr_count"}, n_perr, m_perr);
        chk({tag, ":ferr_count"}, n_ferr, m_ferr);
        chk({tag, ":dataout"}, DataOut, m_last);
        chk({tag, ":idle"}, BusyRx, 1'b0);
    endtask

    // Directed then random stimulus
    initial begin
        RstRx = 1'b1;
        RxSerialData = 1'b1;
        repeat (3) @(negedge CLK_Baudin);
        RstRx = 1'b0;
        #3;
        chk("reset:dataout", DataOut, '0);
        chk("reset:done", DoneRx, 1'b0);
        chk("reset:perr", ParityErr, 1'b0);
        chk("reset:ferr", FrameErr, 1'b0);
        chk("reset:flag", Flag_out, 1'b0);
        chk("reset:busy", BusyRx, 1'b0);
        mon_en = 1'b1;

        send_frame(32'hA5A5_0F0F, 32'h0, 0, 1'b1);
        checkpoint("clean");

        send_frame(32'hA5A5_0F0F, 32'h1234_5678, 1, 1'b1);
        checkpoint("one_retry");

        send_frame(32'h5555_AAAA, 32'h0F0F_0F0F, 4, 1'b1);
        checkpoint("retry_exhausted");

        send_frame(32'h0000_FFFF, 32'h0, 0, 1'b0);
        checkpoint("frame_err");
        send_frame(32'h0000_0001, 32'h0, 0, 1'b1);
        checkpoint("after_frame_err");

        // Reset while data bit 10 is on the line.
        send_bit(1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
        @(negedge CLK_Baudin);
        RxSerialData = 1'b1;
        RstRx = 1'b1;
        @(negedge CLK_Baudin);
        RstRx = 1'b0;
        #3;
        chk("mid_reset:busy", BusyRx, 1'b0);
        chk("mid_reset:dataout", DataOut, '0);
        m_last = '0;
        exp_q.delete();
        checkpoint("mid_reset");
        send_frame(32'hDEAD_BEEF, 32'h0, 0, 1'b1);
        checkpoint("after_reset");

        send_frame(32'hFFFF_FFFF, 32'h0, 0, 1'b1);
        send_frame(32'h8000_0000, 32'h0, 0, 1'b1);
        checkpoint("zero_gap");

        for (int f = 0; f < 24; f++) begin
            logic [W-1:0] w0;
            logic [W-1:0] w1;
            w0 = $urandom;
            w1 = $urandom;
            send_frame(w0, w1, $urandom_range(0, 4), $urandom_range(0, 4) != 0);
            repeat ($urandom_range(0, 2)) send_bit(1'b1);
        end
        checkpoint("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx
